// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC unit for the Y86 pipeline. It owns F_predPC, picks f_pc with corrections
// from M and W, and predicts the next PC using a 2-bit BHT and a return-address stack.
module fetch_pc_predictor #(
    parameter int          ADDR_W    = 64,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          BHT_IDX_W = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          F_stall,
    input  logic [3:0]                    f_icode,
    input  logic [3:0]                    f_ifun,
    input  logic [ADDR_W-1:0]             f_valC,
    input  logic [ADDR_W-1:0]             f_valP,
    input  logic                          M_valid,
    input  logic [3:0]                    M_icode,
    input  logic [3:0]                    M_ifun,
    input  logic                          M_cnd,
    input  logic                          M_pred_taken,
    input  logic [ADDR_W-1:0]             M_pc,
    input  logic [ADDR_W-1:0]             M_valC,
    input  logic [ADDR_W-1:0]             M_valP,
    input  logic                          W_valid,
    input  logic [3:0]                    W_icode,
    input  logic [ADDR_W-1:0]             W_valM,
    input  logic [ADDR_W-1:0]             W_pred_pc,
    output logic [ADDR_W-1:0]             f_pc,
    output logic [ADDR_W-1:0]             F_predPC,
    output logic                          f_pred_taken,
    output logic                          redirect,
    output logic [$clog2(RAS_DEPTH):0]    ras_count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BHT_N = 1 << BHT_IDX_W;

    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    logic [ADDR_W-1:0] f_predpc_reg;
    logic [ADDR_W-1:0] pred_pc_next;
    logic [PTR_W-1:0]  ras_ptr_reg, ras_ptr_next;
    logic [CNT_W-1:0]  ras_count_reg, ras_count_next;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [1:0]        bht_q [BHT_N];

    logic              w_ret_miss, m_jmp_miss;
    logic              bht_upd;
    logic [1:0]        bht_rd;
    logic [PTR_W-1:0]  ras_base_ptr;
    logic [CNT_W-1:0]  ras_base_cnt;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push, ras_pop;

    // Upper PC bits never reach the BHT index.
    logic unused_bits;
    assign unused_bits = ^{M_pc[ADDR_W-1:BHT_IDX_W]};

    // Correction select: W (older instruction) wins over M.
    assign w_ret_miss = W_valid && (W_icode == I_RET) && (W_valM != W_pred_pc);
    assign m_jmp_miss = M_valid && (M_icode == I_JXX) && (M_ifun != 4'h0) && (M_cnd != M_pred_taken);
    assign redirect   = w_ret_miss || m_jmp_miss;

    always_comb begin
        f_pc = f_predpc_reg;
        if (w_ret_miss)
            f_pc = W_valM;
        else if (m_jmp_miss)
            f_pc = M_cnd ? M_valC : M_valP;
    end

    assign F_predPC  = f_predpc_reg;
    assign ras_count = ras_count_reg;
    assign bht_rd    = bht_q[f_pc[BHT_IDX_W-1:0]];

    // A redirect flushes the stack before this cycle's push/pop is applied.
    assign ras_base_ptr = redirect ? '0 : ras_ptr_reg;
    assign ras_base_cnt = redirect ? '0 : ras_count_reg;
    assign ras_top      = ras_mem[ras_base_ptr - 1'b1];

    always_comb begin
        pred_pc_next = f_valP;
        f_pred_taken = 1'b0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        case (f_icode)
            I_JXX: begin
                if (f_ifun == 4'h0) begin
                    pred_pc_next = f_valC;
                    f_pred_taken = 1'b1;
                end else begin
                    f_pred_taken = bht_rd[1];
                    pred_pc_next = bht_rd[1] ? f_valC : f_valP;
                end
            end
            I_CALL: begin
                pred_pc_next = f_valC;
                ras_push     = 1'b1;
            end
            I_RET: begin
                if (ras_base_cnt != '0) begin
                    pred_pc_next = ras_top;
                    ras_pop      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ras_ptr_next   = ras_base_ptr;
        ras_count_next = ras_base_cnt;
        if (ras_push) begin
            ras_ptr_next   = ras_base_ptr + 1'b1;
            // When full, the write slot is the oldest entry, so the count just saturates.
            if (ras_base_cnt != CNT_W'(RAS_DEPTH))
                ras_count_next = ras_base_cnt + 1'b1;
        end else if (ras_pop) begin
            ras_ptr_next   = ras_base_ptr - 1'b1;
            ras_count_next = ras_base_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_predpc_reg  <= RESET_PC[ADDR_W-1:0];
            ras_ptr_reg   <= '0;
            ras_count_reg <= '0;
        end else if (!F_stall) begin
            f_predpc_reg  <= pred_pc_next;
            ras_ptr_reg   <= ras_ptr_next;
            ras_count_reg <= ras_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !F_stall && ras_push)
            ras_mem[ras_base_ptr] <= f_valP;
    end

    // BHT trains from resolved branches even while fetch is stalled.
    assign bht_upd = M_valid && (M_icode == I_JXX) && (M_ifun != 4'h0);

    generate
        for (genvar gi = 0; gi < BHT_N; gi++) begin : g_bht
            logic [1:0] ctr_reg;
            always_ff @(posedge clk) begin
                if (reset)
                    ctr_reg <= 2'b01;
                else if (bht_upd && (M_pc[BHT_IDX_W-1:0] == BHT_IDX_W'(gi))) begin
                    if (M_cnd && ctr_reg != 2'b11)
                        ctr_reg <= ctr_reg + 2'b01;
                    else if (!M_cnd && ctr_reg != 2'b00)
                        ctr_reg <= ctr_reg - 2'b01;
                end
            end
            assign bht_q[gi] = ctr_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: reset, BHT training, jump/ret correction, RAS
// wrap-around, stall hold and reset under stall, all against hand-computed values.
module tb_fetch_pc_predictor;

    logic        clk = 1'b0;
    logic        reset, F_stall;
    logic [3:0]  f_icode, f_ifun;
    logic [63:0] f_valC, f_valP;
    logic        M_valid, M_cnd, M_pred_taken;
    logic [3:0]  M_icode, M_ifun;
    logic [63:0] M_pc, M_valC, M_valP;
    logic        W_valid;
    logic [3:0]  W_icode;
    logic [63:0] W_valM, W_pred_pc;
    logic [63:0] f_pc, F_predPC;
    logic        f_pred_taken, redirect;
    logic [2:0]  ras_count;

    int checks = 0;
    int errors = 0;

    fetch_pc_predictor #(
        .ADDR_W(64), .RESET_PC(64'h100), .BHT_IDX_W(4), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .F_stall(F_stall),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
        .M_valid(M_valid), .M_icode(M_icode), .M_ifun(M_ifun), .M_cnd(M_cnd),
        .M_pred_taken(M_pred_taken), .M_pc(M_pc), .M_valC(M_valC), .M_valP(M_valP),
        .W_valid(W_valid), .W_icode(W_icode), .W_valM(W_valM), .W_pred_pc(W_pred_pc),
        .f_pc(f_pc), .F_predPC(F_predPC), .f_pred_taken(f_pred_taken),
        .redirect(redirect), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("check %s = %0h ok", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp;
    endtask

    task automatic m_jxx(input logic [3:0] fn, input logic cnd, input logic pt,
                         input logic [63:0] pc, input logic [63:0] vc, input logic [63:0] vp);
        M_valid = 1'b1; M_icode = 4'h7; M_ifun = fn; M_cnd = cnd; M_pred_taken = pt;
        M_pc = pc; M_valC = vc; M_valP = vp;
    endtask

    initial begin
        reset = 1'b1; F_stall = 1'b0;
        fetch(4'h0, 4'h0, 64'h0, 64'h0);
        M_valid = 1'b0; M_icode = 4'h0; M_ifun = 4'h0; M_cnd = 1'b0; M_pred_taken = 1'b0;
        M_pc = 64'h0; M_valC = 64'h0; M_valP = 64'h0;
        W_valid = 1'b0; W_icode = 4'h0; W_valM = 64'h0; W_pred_pc = 64'h0;
        step(); step();
        check("rst_predpc", F_predPC, 64'h100);
        check("rst_fpc", f_pc, 64'h100);
        check("rst_ras", 64'(ras_count), 64'd0);
        check("rst_redirect", 64'(redirect), 64'd0);

        reset = 1'b0;
        fetch(4'h1, 4'h0, 64'h0, 64'h101);
        #1 check("nop_fpc", f_pc, 64'h100);
        check("nop_taken", 64'(f_pred_taken), 64'd0);
        step(); check("nop_predpc", F_predPC, 64'h101);

        // jne at 0x20 with fresh BHT (weakly not-taken)
        fetch(4'h1, 4'h0, 64'h0, 64'h20); step();
        fetch(4'h7, 4'h4, 64'h80, 64'h29);
        #1 check("jne_fresh_taken", 64'(f_pred_taken), 64'd0);
        step(); check("jne_fresh_predpc", F_predPC, 64'h29);

        // two taken resolutions train idx 0 to strongly taken
        fetch(4'h1, 4'h0, 64'h0, 64'h20);
        m_jxx(4'h4, 1'b1, 1'b1, 64'h20, 64'h80, 64'h29);
        #1 check("train_no_redirect", 64'(redirect), 64'd0);
        step(); step();
        check("train_predpc", F_predPC, 64'h20);

        // refetch sees counter 3; a same-cycle decrement must not be visible yet
        fetch(4'h7, 4'h4, 64'h80, 64'h29);
        m_jxx(4'h4, 1'b0, 1'b0, 64'h20, 64'h80, 64'h29);
        #1 check("jne_trained_taken", 64'(f_pred_taken), 64'd1);
        step(); M_valid = 1'b0;
        check("jne_trained_predpc", F_predPC, 64'h80);

        // M-stage mispredict correction (combinational)
        m_jxx(4'h4, 1'b1, 1'b0, 64'h20, 64'h80, 64'h29);
        #1 check("mmiss_taken_fpc", f_pc, 64'h80);
        check("mmiss_taken_redirect", 64'(redirect), 64'd1);
        m_jxx(4'h4, 1'b0, 1'b1, 64'h20, 64'h80, 64'h29);
        #1 check("mmiss_nt_fpc", f_pc, 64'h29);
        check("mmiss_nt_redirect", 64'(redirect), 64'd1);
        m_jxx(4'h0, 1'b0, 1'b1, 64'h20, 64'h80, 64'h29);
        #1 check("jmp_uncond_no_redirect", 64'(redirect), 64'd0);
        M_valid = 1'b0;

        // call / ret pair, then ret on empty stack
        fetch(4'h1, 4'h0, 64'h0, 64'h10); step();
        fetch(4'h8, 4'h0, 64'h40, 64'h19); step();
        check("call_predpc", F_predPC, 64'h40);
        check("call_ras", 64'(ras_count), 64'd1);
        fetch(4'h9, 4'h0, 64'h0, 64'h41); step();
        check("ret_predpc", F_predPC, 64'h19);
        check("ret_ras", 64'(ras_count), 64'd0);
        fetch(4'h9, 4'h0, 64'h0, 64'h1a); step();
        check("ret_empty_predpc", F_predPC, 64'h1a);

        // five calls overflow a 4-deep stack; rets return 5th..2nd
        for (int i = 1; i <= 5; i++) begin
            fetch(4'h8, 4'h0, 64'h200, 64'h100 + 64'(i)); step();
        end
        check("ras_full", 64'(ras_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            fetch(4'h9, 4'h0, 64'h0, 64'h1ff); step();
            check($sformatf("ras_pop%0d", i), F_predPC, 64'h105 - 64'(i));
        end
        check("ras_drained", 64'(ras_count), 64'd0);

        // W ret correct vs mispredicted, with simultaneous M mispredict
        fetch(4'h8, 4'h0, 64'h40, 64'h77); step();
        W_valid = 1'b1; W_icode = 4'h9; W_valM = 64'h19; W_pred_pc = 64'h19;
        #1 check("wret_ok_redirect", 64'(redirect), 64'd0);
        check("wret_ok_fpc", f_pc, 64'h40);
        W_valM = 64'h55;
        m_jxx(4'h1, 1'b1, 1'b0, 64'h30, 64'h300, 64'h31);
        fetch(4'h1, 4'h0, 64'h0, 64'h56);
        #1 check("wret_miss_fpc", f_pc, 64'h55);
        check("wret_miss_redirect", 64'(redirect), 64'd1);
        step();
        check("wret_miss_predpc", F_predPC, 64'h56);
        check("wret_miss_ras_clr", 64'(ras_count), 64'd0);
        W_valid = 1'b0; M_valid = 1'b0;

        // stall holds F_predPC and RAS
        F_stall = 1'b1;
        fetch(4'h8, 4'h0, 64'h500, 64'h60);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_predpc", i), F_predPC, 64'h56);
            check($sformatf("stall%0d_ras", i), 64'(ras_count), 64'd0);
        end
        m_jxx(4'h2, 1'b1, 1'b0, 64'h100, 64'h600, 64'h101);
        #1 check("stall_miss_fpc", f_pc, 64'h600);
        step(); check("stall_miss_predpc", F_predPC, 64'h56);

        // reset during a stalled mispredict
        reset = 1'b1; step();
        reset = 1'b0; F_stall = 1'b0; M_valid = 1'b0;
        check("rst2_predpc", F_predPC, 64'h100);
        check("rst2_ras", 64'(ras_count), 64'd0);
        // counter back at 01: not taken now, one taken update flips it
        fetch(4'h7, 4'h4, 64'h900, 64'h100);
        m_jxx(4'h4, 1'b1, 1'b1, 64'h100, 64'h900, 64'h100);
        #1 check("rst2_bht_nt", 64'(f_pred_taken), 64'd0);
        step(); M_valid = 1'b0;
        check("rst2_bht_predpc", F_predPC, 64'h100);
        #1 check("rst2_bht_taken", 64'(f_pred_taken), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
- Next-generation fetch-stage PC unit for the Y86 pipeline.
- Owns the F_predPC register and selects f_pc each cycle, with mispredict/ret correction from M and W.
- Adds what the plain selector lacks:
  - 2-bit-counter branch history table (BHT) for conditional jXX direction prediction.
  - Return-address stack (RAS) for ret target prediction.
  - Fetch stall.
- Sits between the fetch logic (instruction decode of f_pc) and the F pipeline register.

Parameters:
- ADDR_W, 64, PC / data width.
- RESET_PC, 0, F_predPC value after reset.
- BHT_IDX_W, 4, BHT index bits; 2**BHT_IDX_W counters, indexed by pc[BHT_IDX_W-1:0].
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- F_stall  in  1  hold F_predPC, no BHT read effects, no RAS push/pop
- f_icode  in  4  icode of instruction fetched at f_pc
- f_ifun  in  4  ifun of that instruction
- f_valC  in  ADDR_W  constant word (jump/call target)
- f_valP  in  ADDR_W  fall-through PC
- M_valid  in  1  qualifies all M_* inputs; one cycle per instruction
- M_icode  in  4  icode in memory stage
- M_ifun  in  4  ifun in memory stage
- M_cnd  in  1  resolved branch condition
- M_pred_taken  in  1  direction predicted when fetched (carried down pipe)
- M_pc  in  ADDR_W  PC of the M-stage instruction (BHT update index)
- M_valC  in  ADDR_W  taken target
- M_valP  in  ADDR_W  fall-through
- W_valid  in  1  qualifies W_* inputs
- W_icode  in  4  icode in writeback
- W_valM  in  ADDR_W  actual return address
- W_pred_pc  in  ADDR_W  return target predicted at fetch
- f_pc  out  ADDR_W  PC to fetch this cycle (combinational)
- F_predPC  out  ADDR_W  registered predicted PC
- f_pred_taken  out  1  direction predicted for instruction at f_pc (to be piped)
- redirect  out  1  correction active this cycle
- ras_count  out  log2(RAS_DEPTH)+1  valid RAS entries

Behaviour:
- Reset (sync, dominates all other inputs):
  - F_predPC=RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - RAS empty: ras_count=0, pointer 0.
- f_pc selection (combinational), priority order:
  - W_ret_miss = W_valid & W_icode==9 & W_valM!=W_pred_pc → f_pc=W_valM.
  - Else M_jmp_miss = M_valid & M_icode==7 & M_ifun!=0 & (M_cnd!=M_pred_taken) → f_pc = M_cnd ? M_valC : M_valP.
  - Else f_pc=F_predPC.
  - redirect = W_ret_miss | M_jmp_miss.
- Next-PC prediction from f_icode/f_ifun:
  - jXX ifun 0 (jmp): predict f_valC; f_pred_taken=1.
  - jXX ifun!=0: counter = BHT[f_pc idx]; taken if counter[1]=1 → f_valC, else f_valP; f_pred_taken=counter[1].
  - call (8): predict f_valC; push f_valP.
  - ret (9): RAS non-empty → predict top, pop. Empty → predict f_valP, no pop.
  - Others: predict f_valP; f_pred_taken=0.
- Clock edge, when !F_stall:
  - F_predPC <= predicted next PC.
  - Apply RAS push/pop.
- F_stall=1:
  - F_predPC and RAS hold.
  - redirect still drives f_pc combinationally, but no state changes except BHT update.
- RAS:
  - Circular buffer.
  - Push when full overwrites oldest; ras_count saturates at RAS_DEPTH.
  - On redirect: RAS cleared first, then that cycle's push/pop applies to the empty stack (call → count 1; ret → no-op).
- BHT update: on M_valid & M_icode==7 & M_ifun!=0, regardless of stall.
  - BHT[M_pc idx] saturating +1 if M_cnd, −1 otherwise (clamped 0..3).
  - Same-cycle read and update of the same index: read returns the pre-update value.
- W and M both mispredicting: W wins (older instruction). The M correction is dropped, and the squash is handled by pipeline control outside this block.
- No latency beyond the single F_predPC register. Prediction is visible at f_pc the cycle after fetch.

Test Plan:
- Reset, RESET_PC=0x100, then deassert, f_icode=1 (nop), f_valP=0x101 → f_pc=0x100, next cycle F_predPC=0x101; ras_count=0; redirect=0.
- Conditional jne at f_pc=0x20, valC=0x80, valP=0x29, fresh BHT → f_pred_taken=0, F_predPC=0x29. Two M updates with M_cnd=1, M_pc=0x20 → counter=3; refetch predicts 0x80.
- M_valid, M_icode=7, M_ifun=4, M_pred_taken=0, M_cnd=1, M_valC=0x80 → f_pc=0x80, redirect=1 same cycle. With M_pred_taken=1, M_cnd=0, M_valP=0x29 → f_pc=0x29.
- call at 0x10 (valC=0x40, valP=0x19), later ret fetched → F_predPC=0x19, ras_count 1→0. Five calls with RAS_DEPTH=4 → ras_count=4; four rets return the 5th, 4th, 3rd and 2nd call's valP.
- W ret with W_valM=0x55, W_pred_pc=0x19, and a simultaneous M jump mispredict → f_pc=0x55, redirect=1, RAS cleared.
- F_stall=1 for 3 cycles with a call presented → F_predPC and ras_count unchanged. Assert reset during a stalled mispredict → next cycle F_predPC=RESET_PC, ras_count=0, BHT all 01.
